// File: rtl/full_adder_pkg.sv
// Shared constants and types for the 1-bit full adder block.
package full_adder_pkg;

  // Default width of the operation and carry counters.
  localparam int CNT_W_DEFAULT = 16;

  // Counter type at the default width.
  typedef logic [CNT_W_DEFAULT-1:0] cnt_t;

endpackage : full_adder_pkg

// File: rtl/half_adder.sv
// Half adder: sum and carry of two single-bit operands.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule : half_adder

// File: rtl/full_adder_1bit.sv
// 1-bit full adder with a combinational result, a one-cycle registered copy
// qualified by a valid flag, and free-running wrap-around counters of
// accepted operations and of accepted operations that produced a carry.
module full_adder_1bit
  import full_adder_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_a,
  input  logic             i_b,
  input  logic             i_cin,
  input  logic             i_valid,
  output logic             o_sum,
  output logic             o_carry,
  output logic             o_sum_q,
  output logic             o_carry_q,
  output logic             o_valid,
  output logic [CNT_W-1:0] o_op_cnt,
  output logic [CNT_W-1:0] o_carry_cnt
);

  logic             s1;
  logic             c1;
  logic             c2;
  logic             sum_p0;
  logic             carry_p0;

  logic             sum_p1;
  logic             carry_p1;
  logic             vld_p1;
  logic [CNT_W-1:0] op_cnt_p1;
  logic [CNT_W-1:0] carry_cnt_p1;

  // Stage 0: combinational adder from two chained half adders.
  half_adder u_ha0 (
    .a (i_a),
    .b (i_b),
    .s (s1),
    .c (c1)
  );

  half_adder u_ha1 (
    .a (s1),
    .b (i_cin),
    .s (sum_p0),
    .c (c2)
  );

  assign carry_p0 = c1 | c2;
  assign o_sum    = sum_p0;
  assign o_carry  = carry_p0;

  // Stage 1: capture the result when valid; otherwise hold it. The valid
  // flag enters the data path arithmetically / as a mux select so that an
  // unknown valid shows up on the outputs instead of being treated as 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_p1   <= 1'b0;
      carry_p1 <= 1'b0;
      vld_p1   <= 1'b0;
    end else begin
      sum_p1   <= i_valid ? sum_p0   : sum_p1;
      carry_p1 <= i_valid ? carry_p0 : carry_p1;
      vld_p1   <= i_valid;
    end
  end

  // Operation and carry counters; both wrap naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_cnt_p1    <= '0;
      carry_cnt_p1 <= '0;
    end else begin
      op_cnt_p1    <= op_cnt_p1 + {{(CNT_W-1){1'b0}}, i_valid};
      carry_cnt_p1 <= carry_cnt_p1 + {{(CNT_W-1){1'b0}}, i_valid & carry_p0};
    end
  end

  assign o_sum_q     = sum_p1;
  assign o_carry_q   = carry_p1;
  assign o_valid     = vld_p1;
  assign o_op_cnt    = op_cnt_p1;
  assign o_carry_cnt = carry_cnt_p1;

endmodule : full_adder_1bit

// File: tb/tb_full_adder_1bit.sv
// Self-checking bench for full_adder_1bit: one instance at the default
// counter width and one at width 2 for the wrap case, sharing stimulus.
module tb_full_adder_1bit;

  logic        clk;
  logic        rst;
  logic        a;
  logic        b;
  logic        cin;
  logic        valid;

  logic        sum;
  logic        carry;
  logic        sum_q;
  logic        carry_q;
  logic        valid_q;
  logic [15:0] op_cnt;
  logic [15:0] carry_cnt;

  logic        sum2;
  logic        carry2;
  logic        sum_q2;
  logic        carry_q2;
  logic        valid_q2;
  logic [1:0]  op_cnt2;
  logic [1:0]  carry_cnt2;

  int tests;
  int fails;

  full_adder_1bit #(.CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_a         (a),
    .i_b         (b),
    .i_cin       (cin),
    .i_valid     (valid),
    .o_sum       (sum),
    .o_carry     (carry),
    .o_sum_q     (sum_q),
    .o_carry_q   (carry_q),
    .o_valid     (valid_q),
    .o_op_cnt    (op_cnt),
    .o_carry_cnt (carry_cnt)
  );

  full_adder_1bit #(.CNT_W(2)) dut2 (
    .clk         (clk),
    .rst         (rst),
    .i_a         (a),
    .i_b         (b),
    .i_cin       (cin),
    .i_valid     (valid),
    .o_sum       (sum2),
    .o_carry     (carry2),
    .o_sum_q     (sum_q2),
    .o_carry_q   (carry_q2),
    .o_valid     (valid_q2),
    .o_op_cnt    (op_cnt2),
    .o_carry_cnt (carry_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic ia, input logic ib, input logic ic, input logic iv);
    @(negedge clk);
    a     = ia;
    b     = ib;
    cin   = ic;
    valid = iv;
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sum_q"},     {31'd0, sum_q},   32'd0);
    check({tag, "_carry_q"},   {31'd0, carry_q}, 32'd0);
    check({tag, "_valid"},     {31'd0, valid_q}, 32'd0);
    check({tag, "_op_cnt"},    {16'd0, op_cnt},  32'd0);
    check({tag, "_carry_cnt"}, {16'd0, carry_cnt}, 32'd0);
    check({tag, "_op_cnt2"},   {30'd0, op_cnt2}, 32'd0);
  endtask

  // Reference model state for the random run.
  logic m_sum_q;
  logic m_carry_q;
  logic m_valid;
  int   m_ops;
  int   m_carries;

  initial begin
    logic [2:0] v;
    logic [1:0] exp2;
    tests = 0;
    fails = 0;
    rst   = 1'b0;
    a     = 1'b1;
    b     = 1'b0;
    cin   = 1'b1;
    valid = 1'b1;

    // Reset held with a clock running: everything registered stays 0,
    // while the combinational adder still works (1+0+1 = 2'b10).
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    check("reset_comb_sum",   {31'd0, sum},   32'd0);
    check("reset_comb_carry", {31'd0, carry}, 32'd1);

    @(negedge clk);
    valid = 1'b0;
    rst   = 1'b1;

    // Exhaustive combinational sweep with hand-computed {carry,sum}.
    for (int i = 0; i < 8; i++) begin
      v = i[2:0];
      a = v[2]; b = v[1]; cin = v[0];
      case (v)
        3'b000:  exp2 = 2'b00;
        3'b001:  exp2 = 2'b01;
        3'b010:  exp2 = 2'b01;
        3'b011:  exp2 = 2'b10;
        3'b100:  exp2 = 2'b01;
        3'b101:  exp2 = 2'b10;
        3'b110:  exp2 = 2'b10;
        default: exp2 = 2'b11;
      endcase
      #1;
      check($sformatf("comb_%0d", i), {30'd0, carry, sum}, {30'd0, exp2});
    end

    // One accepted operation 1+1+0.
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    edge_sample();
    check("op1_sum_q",     {31'd0, sum_q},   32'd0);
    check("op1_carry_q",   {31'd0, carry_q}, 32'd1);
    check("op1_valid",     {31'd0, valid_q}, 32'd1);
    check("op1_op_cnt",    {16'd0, op_cnt},  32'd1);
    check("op1_carry_cnt", {16'd0, carry_cnt}, 32'd1);

    // Idle edge with changed inputs: registered result holds.
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    edge_sample();
    check("hold_sum_q",     {31'd0, sum_q},   32'd0);
    check("hold_carry_q",   {31'd0, carry_q}, 32'd1);
    check("hold_valid",     {31'd0, valid_q}, 32'd0);
    check("hold_op_cnt",    {16'd0, op_cnt},  32'd1);
    check("hold_carry_cnt", {16'd0, carry_cnt}, 32'd1);
    check("hold_comb_sum",  {31'd0, sum},     32'd1);

    // Four more carrying operations: 5 total, width-2 counters wrap to 1.
    repeat (4) begin
      drive(1'b1, 1'b1, 1'b1, 1'b1);
      edge_sample();
    end
    check("wrap_op_cnt2",    {30'd0, op_cnt2},    32'd1);
    check("wrap_carry_cnt2", {30'd0, carry_cnt2}, 32'd1);
    check("wrap_op_cnt",     {16'd0, op_cnt},     32'd5);
    check("wrap_carry_cnt",  {16'd0, carry_cnt},  32'd5);
    check("wrap_sum_q",      {31'd0, sum_q},      32'd1);

    // Three operations, then asynchronous reset between edges.
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    edge_sample();
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    edge_sample();
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    edge_sample();
    check("pre_rst_op_cnt", {16'd0, op_cnt}, 32'd8);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("async_rst");
    a = 1'b0; b = 1'b1; cin = 1'b1;
    #1;
    check("async_rst_comb", {30'd0, carry, sum}, 32'd2);
    edge_sample();
    check_all_zero("rst_edge");

    // First edge after release accepts an operation.
    @(negedge clk);
    rst = 1'b1;
    a = 1'b1; b = 1'b0; cin = 1'b0; valid = 1'b1;
    edge_sample();
    check("post_rst_op_cnt",    {16'd0, op_cnt},    32'd1);
    check("post_rst_carry_cnt", {16'd0, carry_cnt}, 32'd0);
    check("post_rst_sum_q",     {31'd0, sum_q},     32'd1);
    check("post_rst_valid",     {31'd0, valid_q},   32'd1);

    // Random run against a one-cycle-delayed reference model.
    m_sum_q   = 1'b1;
    m_carry_q = 1'b0;
    m_valid   = 1'b1;
    m_ops     = 1;
    m_carries = 0;
    for (int n = 0; n < 100; n++) begin
      logic ra, rb, rc, rv;
      logic [1:0] tot;
      ra = 1'($urandom_range(0, 1));
      rb = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      rv = ($urandom_range(0, 3) != 0);
      drive(ra, rb, rc, rv);
      tot = 2'(ra) + 2'(rb) + 2'(rc);
      if (rv) begin
        m_sum_q   = tot[0];
        m_carry_q = tot[1];
        m_ops++;
        if (tot[1]) m_carries++;
      end
      m_valid = rv;
      edge_sample();
      check($sformatf("rnd%0d_sum_q", n),     {31'd0, sum_q},     {31'd0, m_sum_q});
      check($sformatf("rnd%0d_carry_q", n),   {31'd0, carry_q},   {31'd0, m_carry_q});
      check($sformatf("rnd%0d_valid", n),     {31'd0, valid_q},   {31'd0, m_valid});
      check($sformatf("rnd%0d_op_cnt", n),    {16'd0, op_cnt},    32'(m_ops & 16'hFFFF));
      check($sformatf("rnd%0d_carry_cnt", n), {16'd0, carry_cnt}, 32'(m_carries & 16'hFFFF));
      check($sformatf("rnd%0d_op_cnt2", n),   {30'd0, op_cnt2},   32'(m_ops & 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_full_adder_1bit
